adder_tree_feeder: RTL
======================

// Module: adder_tree_feeder
// PURPOSE
//  Producer side of the 256x4 adder-tree datapath.
//  - Accepts a WORD_W-bit beat stream over a valid/ready handshake and packs 256 4-bit nibbles into
//    the 1024-bit flat operand vector.
//  - Presents the packed vector to the adder tree and strobes it once per frame.
//  - Pairs each returned sum with its frame using a TREE_LAT-deep strobe delay line.
//  - Sits between the upstream nibble source and the adder tree's data_in_flat/sum_out ports.
// PARAMETERS
//  WORD_W    32   input beat width; must divide NUM_NIB*NIB_W and be a multiple of NIB_W
//  NIB_W     4    operand width
//  NUM_NIB   256  operands per frame
//  BEATS     NUM_NIB*NIB_W/WORD_W (=32)  beats per frame (localparam)
//  TREE_LAT  8    cycles from data_out_flat change to matching sum_in
// PORTS
//  clk            in   1      rising-edge clock
//  reset_n        in   1      asynchronous, active-low reset
//  in_valid       in   1      beat valid
//  in_ready       out  1      beat accepted when in_valid && in_ready
//  in_data        in   WORD_W beat; nibble j of the beat = in_data[4j+3:4j]
//  in_last        in   1      marks final beat of a frame
//  data_out_flat  out  1024   packed operands to adder tree
//  frame_strobe   out  1      1-cycle pulse: data_out_flat holds a new frame
//  sum_in         in   12     adder tree sum_out
//  sum_valid_o    out  1      1-cycle pulse: sum_o holds the sum of one frame
//  sum_o          out  12     captured frame sum
//  frame_err      out  1      sticky: in_last misplaced; cleared only by reset
//  frames_done    out  16     count of sum_valid_o pulses; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset values (async, while reset_n=0): every output and all internal state = 0.
//  - This includes in_ready, beat_cnt, the shadow buffer, the delay line and state (FILL).
//  - in_ready rises on the first clk edge after reset_n deasserts.
//  State machine: FILL, ISSUE.
//  - FILL: in_ready=1. Each accepted beat k writes shadow[WORD_W*k +: WORD_W]; beat_cnt increments.
//    - Nibble n of the frame therefore = data_out_flat[4n+3:4n].
//  - Accepted beat with beat_cnt==BEATS-1 and in_last=1 -> ISSUE; beat_cnt<=0.
//  - ISSUE (exactly 1 cycle): in_ready=0; data_out_flat<=shadow; frame_strobe=1 on the following
//    cycle; then -> FILL.
//  - data_out_flat holds its value until the next ISSUE. The tree is free-running, so the held value
//    keeps producing the same sum.
//  Error cases (frame dropped, no ISSUE, data_out_flat unchanged, beat_cnt<=0):
//  - in_last=1 on a beat with beat_cnt<BEATS-1: frame_err<=1; the partial frame is discarded.
//  - in_last=0 on beat BEATS-1: frame_err<=1; the frame is discarded.
//  - The beat after a drop starts a new frame at beat 0.
//  Throughput: one bubble (in_ready=0) per frame. Max rate = 1 frame per BEATS+1 cycles.
//  Return path:
//  - Shift register dly[TREE_LAT-1:0] shifts in frame_strobe each cycle.
//  - When dly[TREE_LAT-1]=1: sum_o<=sum_in, sum_valid_o=1 for 1 cycle, frames_done+=1.
//  - sum_o holds between pulses.
//  - Multiple frames may be in flight, bounded by ceil(TREE_LAT/(BEATS+1)).
//  Arithmetic: no arithmetic is done on data. beat_cnt is clog2(BEATS) bits wide and never wraps
//  silently, because it is cleared at end of frame.
//  Reset mid-operation: the partial frame and all in-flight strobes are lost.
//  - No sum_valid_o may appear after reset_n deasserts until a new frame has been issued.
//  in_valid=0 mid-frame: beat_cnt holds and state stays FILL, with no timeout.
//  in_data/in_last are ignored when in_valid=0.
// TESTING
//  T1 32 beats of 32'h1111_1111, last on beat 31.
//     -> frame_strobe 1 cycle after beat 31; sum_valid_o 8 cycles later; sum_o=256; frames_done=1.
//  T2 All beats 32'hFFFF_FFFF -> sum_o=3840 (0xF00); frame_err=0.
//  T3 Nibble n=(n%16), i.e. beat 32'h7654_3210 / 32'hFEDC_BA98 alternating -> sum_o=1920.
//  T4 in_valid held 1 for 3 frames (T1, T2, T3 data).
//     -> in_ready low exactly 1 cycle per 33; sum_valid_o pulses 33 cycles apart with
//        sum_o=256, 3840, 1920.
//  T5 in_last on beat 5, then a T1 frame -> frame_err=1 stays set; no strobe for the bad frame;
//     next sum_o=256.
//  T6 reset_n pulsed low 3 cycles after frame_strobe
//     -> all outputs 0 immediately; no sum_valid_o for 20 cycles with in_valid=0.

Source files
------------

// File: rtl/adder_tree_feeder.sv
// Producer side of the adder-tree datapath: packs a beat stream into the flat operand
// vector, strobes each complete frame into the tree and pairs the returned sums with frames.
module adder_tree_feeder #(
    parameter int WORD_W   = 32,
    parameter int NIB_W    = 4,
    parameter int NUM_NIB  = 256,
    parameter int TREE_LAT = 8,
    localparam int FLAT_W  = NUM_NIB * NIB_W,
    localparam int SUM_W   = NIB_W + $clog2(NUM_NIB),
    localparam int BEATS   = FLAT_W / WORD_W,
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic [FLAT_W-1:0] data_out_flat,
    output logic              frame_strobe,
    input  logic [SUM_W-1:0]  sum_in,
    output logic              sum_valid_o,
    output logic [SUM_W-1:0]  sum_o,
    output logic              frame_err,
    output logic [15:0]       frames_done
);

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [FLAT_W-1:0]   shadow_q, shadow_d;
    logic [FLAT_W-1:0]   data_out_q, data_out_d;
    logic                frame_strobe_q, frame_strobe_d;
    logic [TREE_LAT-1:0] dly_q, dly_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic                frame_err_q, frame_err_d;
    logic [15:0]         frames_done_q, frames_done_d;

    logic accept;
    logic last_slot;

    assign accept    = in_valid && in_ready_q;
    assign last_slot = (beat_cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        shadow_d       = shadow_q;
        data_out_d     = data_out_q;
        frame_strobe_d = 1'b0;
        frame_err_d    = frame_err_q;
        sum_d          = sum_q;
        frames_done_d  = frames_done_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    shadow_d[WORD_W*beat_cnt_q +: WORD_W] = in_data;
                    if (in_last && last_slot) begin
                        state_d    = ISSUE;
                        beat_cnt_d = '0;
                    end else if (in_last || last_slot) begin
                        // Misplaced or missing in_last: drop the frame and resync at beat 0.
                        frame_err_d = 1'b1;
                        beat_cnt_d  = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                data_out_d     = shadow_q;
                frame_strobe_d = 1'b1;
                state_d        = FILL;
            end
            default: state_d = FILL;
        endcase

        in_ready_d = (state_d == FILL);

        // Strobe delay line lines up with the tree latency; its tail marks a valid sum_in.
        dly_d = (dly_q << 1) | TREE_LAT'(frame_strobe_q);
        if (dly_q[TREE_LAT-1]) begin
            sum_d         = sum_in;
            frames_done_d = frames_done_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples the
    // values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= FILL;
            in_ready_q     <= 1'b0;
            beat_cnt_q     <= '0;
            // NOTE: the wide shadow buffer is reset too, so a dropped first frame can never
            // expose stale contents on data_out_flat.
            shadow_q       <= '0;
            data_out_q     <= '0;
            frame_strobe_q <= 1'b0;
            dly_q          <= '0;
            sum_q          <= '0;
            frame_err_q    <= 1'b0;
            frames_done_q  <= '0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            beat_cnt_q     <= beat_cnt_d;
            shadow_q       <= shadow_d;
            data_out_q     <= data_out_d;
            frame_strobe_q <= frame_strobe_d;
            dly_q          <= dly_d;
            sum_q          <= sum_d;
            frame_err_q    <= frame_err_d;
            frames_done_q  <= frames_done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign data_out_flat = data_out_q;
    assign frame_strobe  = frame_strobe_q;
    assign sum_valid_o   = dly_q[TREE_LAT-1];
    // During the pulse the live tree output is the frame's sum; it is held afterwards.
    assign sum_o         = sum_valid_o ? sum_in : sum_q;
    assign frame_err     = frame_err_q;
    assign frames_done   = frames_done_q;

endmodule
